// File: rtl/rdout_seq_ctrl.sv
// Readout sequencer: turns timer/strobe requests into snap, clear and a paced increment train
// for the counter word-mux, then handshakes every word into the serializer and checks done timing.
module rdout_seq_ctrl #(
    parameter int NWORDS = 54,
    parameter int PERIOD = 50000,
    parameter int INC_W  = 2,
    parameter int SETTLE = 4,
    parameter int TX_TMO = 1023
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_req,
    input  logic       rdout_done,
    input  logic       tx_busy,
    output logic       snap,
    output logic       clr_rdout,
    output logic       increment,
    output logic       tx_start,
    output logic       busy,
    output logic       frame_done,
    output logic       seq_err,
    output logic [7:0] miss_cnt
);

    localparam int TMR_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CNT_MX0 = (INC_W > SETTLE) ? INC_W : SETTLE;
    localparam int CNT_MAX = (CNT_MX0 > TX_TMO) ? CNT_MX0 : TX_TMO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] INC_LAST    = CNT_W'(INC_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TX_TMO - 1);
    localparam logic [6:0]       NW7         = 7'(NWORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SNAP,
        S_CLR,
        S_INC_HI,
        S_SETTLE,
        S_TX_REQ,
        S_TX_RISE,
        S_TX_FALL,
        S_FINISH
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       word_cnt;
    logic             pending;
    logic             done_seen;
    logic             tick;
    logic             req;
    logic             consume;

    assign tick    = enable && (timer == TMR_LAST);
    assign req     = enable && (tick || frame_req);
    assign consume = (state == S_IDLE) && pending;

    // Free-running request timer, parked at zero while disabled
    always_ff @(posedge clk50) begin
        if (rst || !enable) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // One-deep request queue; a request landing on the consume cycle merges into that frame
    always_ff @(posedge clk50) begin
        if (rst) begin
            pending  <= 1'b0;
            miss_cnt <= 8'd0;
        end else if (consume) begin
            pending <= 1'b0;
        end else if (req) begin
            if (pending) begin
                if (miss_cnt != 8'hFF) begin
                    miss_cnt <= miss_cnt + 8'd1;
                end
            end else begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            word_cnt   <= 7'd0;
            done_seen  <= 1'b0;
            snap       <= 1'b0;
            clr_rdout  <= 1'b0;
            increment  <= 1'b0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            snap       <= 1'b0;
            clr_rdout  <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        state   <= S_SNAP;
                        snap    <= 1'b1;
                        busy    <= 1'b1;
                        seq_err <= 1'b0;
                    end
                end
                S_SNAP: begin
                    word_cnt  <= 7'd0;
                    done_seen <= 1'b0;
                    clr_rdout <= 1'b1;
                    state     <= S_CLR;
                end
                S_CLR: begin
                    increment <= 1'b1;
                    word_cnt  <= word_cnt + 7'd1;
                    cnt       <= '0;
                    state     <= S_INC_HI;
                end
                S_INC_HI: begin
                    if (cnt == INC_LAST) begin
                        increment <= 1'b0;
                        cnt       <= '0;
                        state     <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    // The mux word and its done flag are only trusted on the last settle cycle
                    if (cnt == SETTLE_LAST) begin
                        done_seen <= rdout_done;
                        if (rdout_done && (word_cnt < NW7)) begin
                            seq_err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= S_TX_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TX_REQ: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        cnt      <= '0;
                        state    <= S_TX_RISE;
                    end else if (cnt == TMO_LAST) begin
                        seq_err    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TX_RISE: begin
                    if (tx_busy) begin
                        cnt   <= '0;
                        state <= S_TX_FALL;
                    end else if (cnt == TMO_LAST) begin
                        seq_err    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TX_FALL: begin
                    if (!tx_busy) begin
                        cnt <= '0;
                        if (done_seen) begin
                            frame_done <= 1'b1;
                            state      <= S_FINISH;
                        end else if (word_cnt == NW7) begin
                            seq_err    <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            increment <= 1'b1;
                            word_cnt  <= word_cnt + 7'd1;
                            state     <= S_INC_HI;
                        end
                    end else if (cnt == TMO_LAST) begin
                        seq_err    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    increment <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rdout_seq_ctrl.md
Name: rdout_seq_ctrl

Overview:
- Sequencer for the 53-word counter readout path.
- Accepts frame requests from a periodic timer or an external strobe and issues the snapshot strobe for the counter bank.
- Drives clr_rdout and a paced increment pulse train into the readout word-mux, then handshakes each resulting 10-bit word into the downstream serializer.
- Checks that the mux's rdout_done arrives exactly on the last increment, and flags missed frames and sequencing errors.

Parameters:
NWORDS, 54, increments per frame (53 data words plus trailer); rdout_done expected on increment NWORDS
PERIOD, 50000, timer request interval in clk50 cycles (≥ 1000)
INC_W, 2, increment high time in cycles (≥ 1)
SETTLE, 4, cycles after increment falls before the word is valid (≥ 3)
TX_TMO, 1023, max cycles waiting on each serializer handshake phase

Ports:
clk50  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  gates the timer and frame_req; an in-progress frame always completes
frame_req  in  1  single-cycle external request
rdout_done  in  1  done flag from the readout mux
tx_busy  in  1  serializer busy
snap  out  1  one-cycle pulse; counter bank latches words_in
clr_rdout  out  1  one-cycle pulse to the mux
increment  out  1  paced increment level to the mux
tx_start  out  1  one-cycle request to send the current mux word
busy  out  1  high from SNAP through FINISH
frame_done  out  1  one-cycle pulse at FINISH
seq_err  out  1  sticky error; cleared on snap of the next frame
miss_cnt  out  8  dropped requests, saturating at 255

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all outputs 0, miss_cnt=0.
  - state=IDLE, timer=0, pending=0, word_cnt=0, done_seen=0.
  - Reset mid-frame aborts immediately; increment drops the next cycle.
- Timer:
  - while enable=1, counts 0..PERIOD-1; tick on PERIOD-1, then wraps to 0.
  - while enable=0, held at 0.
- Request capture: req = enable & (tick | frame_req).
  - A simultaneous tick and frame_req count as one request.
  - req sets pending.
  - If pending is already 1, or state≠IDLE and pending=1, miss_cnt++ (saturating at 255).
  - A req in the same cycle IDLE consumes pending is merged; no miss and no new pending.
- States:
  - IDLE: if pending, clear pending → SNAP.
  - SNAP: snap=1 for 1 cycle; seq_err←0; word_cnt←0 → CLR.
  - CLR: clr_rdout=1 for 1 cycle → INC_HI.
  - INC_HI: increment=1 for INC_W cycles; word_cnt++ on entry → SETTLE.
  - SETTLE: increment=0 for SETTLE cycles.
    - On the last cycle, done_seen←rdout_done.
    - If rdout_done=1 and word_cnt<NWORDS, seq_err←1 (early done).
    - → TX_REQ.
  - TX_REQ: wait for tx_busy=0, then tx_start=1 for 1 cycle → TX_WAIT.
  - TX_WAIT: wait for tx_busy to rise, then fall → next.
    - Each phase is limited to TX_TMO cycles; on timeout, seq_err←1 → FINISH.
  - Next after TX_WAIT:
    - if done_seen → FINISH.
    - else if word_cnt==NWORDS → seq_err←1 (missing done) → FINISH.
    - else → INC_HI.
  - FINISH: frame_done=1 for 1 cycle; increment=0 → IDLE.
- Latency and pacing:
  - First increment rises 3 cycles after pending is seen in IDLE.
  - Minimum increment period is INC_W+SETTLE+2+serializer time.
  - Edges are spaced far enough for the mux's 2-stage edge detector.
- Widths: word_cnt is 7 bits, compared unsigned to NWORDS.
- A nominal frame is exactly NWORDS tx_start pulses, with done_seen set on increment NWORDS only.

Test Plan:
1. Nominal frame: frame_req, rdout_done model rising after increment 54, tx_busy 8 cycles per word → 54 tx_start pulses, 54 increment pulses each 2 cycles wide, one frame_done, seq_err=0, miss_cnt=0.
2. Early done: model asserts rdout_done after increment 30 → seq_err=1, 30 tx_start pulses, frame_done pulse; next frame's snap clears seq_err.
3. Missing done: rdout_done never rises → 54 tx_start pulses, then seq_err=1, frame_done; no 55th increment.
4. Request overload: PERIOD=1000 with tx_busy 40 cycles per word (frame ≈ 2600 cycles) → tick accepted as pending during frame, further ticks counted; miss_cnt increments, saturates at 255, never wraps.
5. Serializer stuck: tx_busy held high after first tx_start → timeout after 1023 cycles, seq_err=1, frame_done, busy=0.
6. Reset mid-frame: rst=1 during INC_HI of word 10 → next cycle increment=0, busy=0, miss_cnt=0, state IDLE; fresh frame_req restarts from snap.
